// File: rtl/td4_prog_loader.sv
// TD4 program store: 16-byte instruction memory loaded through a slow asynchronous
// strobe interface, read combinationally by the core's pc while in RUN.
module td4_prog_loader #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       prog_en,
  input  logic       wr_strobe,
  input  logic [7:0] wr_data,
  input  logic [3:0] pc,
  output logic [3:0] opcode,
  output logic [3:0] immediate,
  output logic       cpu_rst_n,
  output logic [3:0] load_addr,
  output logic [4:0] word_count
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_LOAD = 3'b010,
    ST_RUN  = 3'b100
  } state_t;

  logic [SYNC_STAGES-1:0] prog_sync_r;
  logic [SYNC_STAGES-1:0] strb_sync_r;
  logic                   strb_prev_r;
  logic                   prog_req_s;
  logic                   strobe_pulse_s;
  logic                   write_en_s;
  state_t                 state_r;
  logic [3:0]             load_addr_r;
  logic [4:0]             word_count_r;
  logic [7:0]             mem_r [16];
  logic [7:0]             rd_byte_s;

  // Synchronize the asynchronous pins and keep the previous strobe for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prog_sync_r <= '0;
      strb_sync_r <= '0;
      strb_prev_r <= 1'b0;
    end else begin
      prog_sync_r <= {prog_sync_r[SYNC_STAGES-2:0], prog_en};
      strb_sync_r <= {strb_sync_r[SYNC_STAGES-2:0], wr_strobe};
      strb_prev_r <= strb_sync_r[SYNC_STAGES-1];
    end
  end

  assign prog_req_s     = prog_sync_r[SYNC_STAGES-1];
  assign strobe_pulse_s = strb_sync_r[SYNC_STAGES-1] & ~strb_prev_r;
  // A pulse landing on the LOAD->RUN edge is still taken because the state is still LOAD.
  assign write_en_s     = (state_r == ST_LOAD) & strobe_pulse_s;

  // Mode state machine with the load address and saturating byte counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      load_addr_r  <= 4'd0;
      word_count_r <= 5'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (prog_req_s) begin
            state_r      <= ST_LOAD;
            load_addr_r  <= 4'd0;
            word_count_r <= 5'd0;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_LOAD: begin
          if (strobe_pulse_s) begin
            load_addr_r <= load_addr_r + 4'd1;
            if (word_count_r != 5'd16) begin
              word_count_r <= word_count_r + 5'd1;
            end else begin
              word_count_r <= word_count_r;
            end
          end else begin
            load_addr_r <= load_addr_r;
          end
          if (!prog_req_s) begin
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_LOAD;
          end
        end
        ST_RUN: begin
          if (prog_req_s) begin
            state_r      <= ST_LOAD;
            load_addr_r  <= 4'd0;
            word_count_r <= 5'd0;
          end else begin
            state_r <= ST_RUN;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          load_addr_r  <= 4'd0;
          word_count_r <= 5'd0;
        end
      endcase
    end
  end

  // Instruction storage; every entry resets to ADD A,0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else if (write_en_s) begin
      mem_r[load_addr_r] <= wr_data;
    end
  end

  // Zero-latency instruction fetch, forced to zero unless the core is running
  always_comb begin
    rd_byte_s = 8'h00;
    if (state_r == ST_RUN) begin
      rd_byte_s = mem_r[pc];
    end else begin
      rd_byte_s = 8'h00;
    end
  end

  assign opcode     = rd_byte_s[7:4];
  assign immediate  = rd_byte_s[3:0];
  assign cpu_rst_n  = (state_r == ST_RUN);
  assign load_addr  = load_addr_r;
  assign word_count = word_count_r;

endmodule
